// File: rtl/fb_pkg.sv
// Types shared by the framebuffer writer and reader: pixel format, default
// frame geometry, streaming FSM states and the tagged FIFO word.
package fb_pkg;

  localparam int FB_WIDTH_DEFAULT  = 240;
  localparam int FB_HEIGHT_DEFAULT = 320;
  localparam int PIXEL_W           = 12;

  // RGB444
  typedef logic [PIXEL_W-1:0] pixel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_e;

  typedef struct packed {
    logic   line_end;
    logic   frame_end;
    pixel_t pix;
  } fifo_word_t;

  localparam int FIFO_WORD_W = $bits(fifo_word_t);

endpackage

// File: rtl/pixel_fifo.sv
// Small circular FIFO for tagged pixels, with an occupancy count used as
// read credit by the framebuffer reader. Synchronous active-low reset.
module pixel_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 14,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CNT_FULL) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (do_pop && !do_push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: emptiness is tracked by the pointers and count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/framebuffer_reader.sv
// Streams one frame from BRAM in raster order onto a pixel stream, limiting
// reads so every word still in the BRAM pipeline has a FIFO slot reserved.
module framebuffer_reader
  import fb_pkg::*;
#(
  parameter  int FRAME_WIDTH  = FB_WIDTH_DEFAULT,
  parameter  int FRAME_HEIGHT = FB_HEIGHT_DEFAULT,
  parameter  int BRAM_LATENCY = 2,
  localparam int ADDR_W       = $clog2(FRAME_WIDTH * FRAME_HEIGHT),
  localparam int FIFO_DEPTH   = BRAM_LATENCY + 2,
  localparam int CNT_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] bram_addr,
  input  pixel_t            bram_data_out,
  // Stream: a pixel moves on every edge with axiov && axiord; while axiov is
  // high and axiord low, axiod/axiol/frame_done hold and axiov stays high.
  input  logic              axiord,
  output logic              axiov,
  output pixel_t            axiod,
  output logic              axiol,
  output logic              frame_done,
  output logic              busy,
  output fb_state_e         dbg_state_o
);

  localparam logic [ADDR_W-1:0] FW_A      = ADDR_W'(FRAME_WIDTH);
  localparam logic [ADDR_W-1:0] HC_LAST   = ADDR_W'(FRAME_WIDTH - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(FRAME_WIDTH * FRAME_HEIGHT - 1);

  fb_state_e               state_q, state_d;
  logic [ADDR_W-1:0]       hcount_q, hcount_d;
  logic [ADDR_W-1:0]       liney_q, liney_d;
  logic [BRAM_LATENCY-1:0] iv_q, iv_d;
  logic [BRAM_LATENCY-1:0] le_q, le_d;
  logic [BRAM_LATENCY-1:0] fe_q, fe_d;
  logic                    issue, room, line_end, frame_end, xfer;
  logic [CNT_W-1:0]        fifo_count;
  logic                    fifo_empty;
  logic [FIFO_WORD_W-1:0]  fifo_dout;
  fifo_word_t              push_word, head;

  assign bram_addr = liney_q * FW_A + hcount_q;
  assign line_end  = (hcount_q == HC_LAST);
  assign frame_end = (bram_addr == ADDR_LAST);
  assign room      = (int'(fifo_count) + $countones(iv_q)) < FIFO_DEPTH;

  // Counters sit at zero in IDLE, so the start cycle itself issues address 0.
  always_comb begin
    state_d  = state_q;
    hcount_d = hcount_q;
    liney_d  = liney_q;
    issue    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          issue   = 1'b1;
          state_d = ST_READ;
        end
      end
      ST_READ:  issue = room;
      ST_DRAIN: if (xfer && head.frame_end) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    if (issue) begin
      if (frame_end) begin
        hcount_d = '0;
        liney_d  = '0;
        state_d  = ST_DRAIN;
      end else if (line_end) begin
        hcount_d = '0;
        liney_d  = liney_q + 1'b1;
      end else begin
        hcount_d = hcount_q + 1'b1;
      end
    end
  end

  always_comb begin
    iv_d    = iv_q << 1;
    le_d    = le_q << 1;
    fe_d    = fe_q << 1;
    iv_d[0] = issue;
    le_d[0] = issue && line_end;
    fe_d[0] = issue && frame_end;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      hcount_q <= '0;
      liney_q  <= '0;
      iv_q     <= '0;
      le_q     <= '0;
      fe_q     <= '0;
    end else begin
      state_q  <= state_d;
      hcount_q <= hcount_d;
      liney_q  <= liney_d;
      iv_q     <= iv_d;
      le_q     <= le_d;
      fe_q     <= fe_d;
    end
  end

  assign push_word = {le_q[BRAM_LATENCY-1], fe_q[BRAM_LATENCY-1], bram_data_out};

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FIFO_WORD_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (iv_q[BRAM_LATENCY-1]),
    .din_i   (push_word),
    .pop_i   (xfer),
    .dout_o  (fifo_dout),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign head        = fifo_dout;
  assign axiov       = !fifo_empty;
  assign xfer        = axiov && axiord;
  assign axiod       = axiov ? head.pix : '0;
  assign axiol       = axiov && head.line_end;
  assign frame_done  = axiov && head.frame_end;
  assign busy        = (state_q != ST_IDLE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_framebuffer_reader.sv
// Bench for framebuffer_reader: a 4x3 instance under varied ready patterns and
// resets, plus a default 240x320 instance streamed once end to end.
`timescale 1ns/1ps
module tb_framebuffer_reader;
  import fb_pkg::*;

  localparam int SW  = 4;
  localparam int SH  = 3;
  localparam int SN  = SW * SH;
  localparam int BW  = 240;
  localparam int BH  = 320;
  localparam int BN  = BW * BH;
  localparam int LAT = 2;

  // ---------------- clock ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic        rst_s, start_s, axiord_s;
  logic [3:0]  addr_s;
  logic [11:0] data_s, axiod_s;
  logic        axiov_s, axiol_s, fd_s, busy_s;
  fb_state_e   st_s;

  framebuffer_reader #(.FRAME_WIDTH(SW), .FRAME_HEIGHT(SH), .BRAM_LATENCY(LAT)) u_small (
    .clk(clk), .rst(rst_s), .start(start_s), .bram_addr(addr_s), .bram_data_out(data_s),
    .axiord(axiord_s), .axiov(axiov_s), .axiod(axiod_s), .axiol(axiol_s),
    .frame_done(fd_s), .busy(busy_s), .dbg_state_o(st_s)
  );

  // ---------------- default-size instance ----------------
  logic        rst_b, start_b, axiord_b;
  logic [16:0] addr_b;
  logic [11:0] data_b, axiod_b;
  logic        axiov_b, axiol_b, fd_b, busy_b;
  fb_state_e   st_b;

  framebuffer_reader u_big (
    .clk(clk), .rst(rst_b), .start(start_b), .bram_addr(addr_b), .bram_data_out(data_b),
    .axiord(axiord_b), .axiov(axiov_b), .axiod(axiod_b), .axiol(axiol_b),
    .frame_done(fd_b), .busy(busy_b), .dbg_state_o(st_b)
  );

  // ---------------- BRAM models: word at address a holds a[11:0] ----------------
  logic [3:0]  sp_q [LAT];
  logic [16:0] bp_q [LAT];
  always @(posedge clk) begin
    sp_q[0] <= addr_s;
    bp_q[0] <= addr_b;
    for (int k = 1; k < LAT; k++) begin
      sp_q[k] <= sp_q[k-1];
      bp_q[k] <= bp_q[k-1];
    end
  end
  assign data_s = {8'h00, sp_q[LAT-1]};
  assign data_b = bp_q[LAT-1][11:0];

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];
  int          s_xfers = 0;
  logic        prev_stall = 1'b0;
  logic [13:0] prev_out = '0;
  logic [15:0] e_idx;
  int          big_idx = 0;
  int          big_fd = 0;
  logic [16:0] big_max_addr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Pixel i of a w-wide, n-pixel frame: {line_end, frame_end, pixel}.
  function automatic logic [13:0] model_word(input int idx, input int w, input int n);
    logic [11:0] pix;
    pix = 12'(idx);
    return {(idx % w) == (w - 1), idx == (n - 1), pix};
  endfunction

  always @(negedge clk) begin
    if (!rst_s) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {18'd0, axiov_s, axiol_s, fd_s, axiod_s}, {18'd0, 1'b1, prev_out});
      if (axiov_s && axiord_s) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL extra_pixel: got pixel %0d with none expected", axiod_s);
        end else begin
          e_idx = exp_q.pop_front();
          check("small_pixel", {18'd0, axiol_s, fd_s, axiod_s}, {18'd0, model_word(int'(e_idx), SW, SN)});
        end
        s_xfers++;
      end
      check("fifo_bound", {31'd0, u_small.u_fifo.count_o <= 3'd4}, 32'd1);
      prev_stall = axiov_s && !axiord_s;
      prev_out   = {axiol_s, fd_s, axiod_s};
    end
    if (rst_b && axiov_b && axiord_b) begin
      check("big_pixel", {18'd0, axiol_b, fd_b, axiod_b}, {18'd0, model_word(big_idx, BW, BN)});
      big_idx++;
      if (fd_b) big_fd++;
    end
    if (rst_b && busy_b && (addr_b > big_max_addr)) big_max_addr = addr_b;
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_small();
    for (int i = 0; i < SN; i++) exp_q.push_back(16'(i));
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
  endtask

  task automatic check_small_reset(input string tag);
    check({tag, "_axiov"}, {31'd0, axiov_s}, 32'd0);
    check({tag, "_axiol"}, {31'd0, axiol_s}, 32'd0);
    check({tag, "_fdone"}, {31'd0, fd_s}, 32'd0);
    check({tag, "_busy"},  {31'd0, busy_s}, 32'd0);
    check({tag, "_addr"},  {28'd0, addr_s}, 32'd0);
    check({tag, "_axiod"}, {20'd0, axiod_s}, 32'd0);
    check({tag, "_state"}, {30'd0, st_s}, {30'd0, ST_IDLE});
  endtask

  task automatic wait_small_done(input int budget);
    int cyc;
    cyc = 0;
    while ((busy_s || exp_q.size() != 0) && cyc < budget) begin
      tick();
      cyc++;
    end
    check("frame_complete", {31'd0, busy_s || exp_q.size() != 0}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int base;
    int cyc;
    rst_s = 1'b0; rst_b = 1'b0;
    start_s = 1'b0; start_b = 1'b0;
    axiord_s = 1'b1; axiord_b = 1'b1;
    repeat (3) tick();
    check_small_reset("rst");
    check("big_rst", {11'd0, axiov_b, axiol_b, fd_b, busy_b, addr_b}, 32'd0);
    rst_s = 1'b1; rst_b = 1'b1;
    tick();

    // Full-rate stream: first pixel at cycle 3, then one per cycle.
    base = s_xfers;
    start_small();
    lat = 1;
    while (!axiov_s && lat < 20) begin
      tick();
      lat++;
    end
    check("first_latency", lat, LAT + 1);
    for (int k = 0; k < SN; k++) begin
      check("t1_valid", {31'd0, axiov_s}, 32'd1);
      check("t1_data",  {20'd0, axiod_s}, k);
      check("t1_axiol", {31'd0, axiol_s}, {31'd0, (k == 3 || k == 7 || k == 11)});
      check("t1_fdone", {31'd0, fd_s}, {31'd0, (k == 11)});
      tick();
    end
    check("t1_busy_end", {31'd0, busy_s}, 32'd0);
    check("t1_count", s_xfers - base, SN);

    // Random ready at about 30%.
    base = s_xfers;
    axiord_s = ($urandom_range(0, 99) < 30);
    start_small();
    cyc = 0;
    while ((busy_s || exp_q.size() != 0) && cyc < 2000) begin
      axiord_s = ($urandom_range(0, 99) < 30);
      tick();
      cyc++;
    end
    check("t2_done", {31'd0, busy_s || exp_q.size() != 0}, 32'd0);
    check("t2_count", s_xfers - base, SN);
    axiord_s = 1'b1;
    tick();

    // Ready low for 20 cycles: credit allows exactly FIFO_DEPTH reads.
    base = s_xfers;
    axiord_s = 1'b0;
    start_small();
    repeat (19) tick();
    check("t3_addr",  {28'd0, addr_s}, 32'd4);
    check("t3_valid", {31'd0, axiov_s}, 32'd1);
    check("t3_data",  {20'd0, axiod_s}, 32'd0);
    check("t3_fifo",  {29'd0, u_small.u_fifo.count_o}, 32'd4);
    axiord_s = 1'b1;
    wait_small_done(200);
    check("t3_count", s_xfers - base, SN);

    // Reset while pixel 5 is presented, then restart from 0.
    start_small();
    cyc = 0;
    while (!(axiov_s && axiod_s == 12'd5) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("t4_reach5", {20'd0, axiod_s}, 32'd5);
    rst_s = 1'b0;
    tick();
    check_small_reset("t4_rst");
    tick();
    rst_s = 1'b1;
    repeat (4) begin
      tick();
      check("t4_no_stale", {31'd0, axiov_s}, 32'd0);
    end
    base = s_xfers;
    start_small();
    repeat (2) tick();
    for (int k = 0; k < SN; k++) begin
      check("t4_data", {20'd0, axiod_s}, k);
      tick();
    end
    check("t4_count", s_xfers - base, SN);

    // Starts mid-frame and on the final-transfer cycle must be ignored.
    base = s_xfers;
    start_small();
    repeat (4) tick();
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    cyc = 0;
    while (!(axiov_s && fd_s) && cyc < 50) begin
      tick();
      cyc++;
    end
    check("t5_final_seen", {31'd0, fd_s}, 32'd1);
    start_s = 1'b1;
    tick();
    start_s = 1'b0;
    repeat (10) tick();
    check("t5_count", s_xfers - base, SN);
    check("t5_busy",  {31'd0, busy_s}, 32'd0);
    check("t5_valid", {31'd0, axiov_s}, 32'd0);

    // Default geometry: full 76800-pixel frame.
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    cyc = 0;
    while (busy_b && cyc < 80000) begin
      tick();
      cyc++;
    end
    tick();
    check("big_busy_end", {31'd0, busy_b}, 32'd0);
    check("big_transfers", big_idx, BN);
    check("big_frame_done", big_fd, 1);
    check("big_last_addr", {15'd0, big_max_addr}, 32'd76799);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/framebuffer_reader.md
FRAMEBUFFER_READER -- requirements
Module: framebuffer_reader

Interface
REQ-001 The block SHALL have parameter FRAME_WIDTH, default 240, giving pixels per line.
REQ-002 The block SHALL have parameter FRAME_HEIGHT, default 320, giving lines per frame.
REQ-003 The block SHALL have parameter BRAM_LATENCY, default 2, giving cycles from bram_addr to valid bram_data_out.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to stream one frame.
REQ-007 The block SHALL have port bram_addr, output, ADDR_W = $clog2(FRAME_WIDTH*FRAME_HEIGHT) bits (17 at defaults): BRAM read address.
REQ-008 The block SHALL have port bram_data_out, input, 12 bits: BRAM read data, valid BRAM_LATENCY cycles after its address.
REQ-009 The block SHALL have port axiord, input, 1 bit: downstream ready.
REQ-010 The block SHALL have port axiov, output, 1 bit: pixel valid.
REQ-011 The block SHALL have port axiod, output, 12 bits: pixel data, RGB444.
REQ-012 The block SHALL have port axiol, output, 1 bit: asserted with the last pixel of each line.
REQ-013 The block SHALL have port frame_done, output, 1 bit: asserted with the last pixel of the frame.
REQ-014 The block SHALL have port busy, output, 1 bit: high from accepted start until the last pixel is transferred.

Function
REQ-015 A transfer SHALL occur on every cycle with axiov && axiord; while axiov && !axiord, axiov, axiod, axiol and frame_done SHALL hold their values.
REQ-016 The FSM SHALL have states IDLE, READ and DRAIN, with transitions IDLE->READ on start, READ->DRAIN after issuing address FRAME_WIDTH*FRAME_HEIGHT-1, and DRAIN->IDLE on the transfer carrying frame_done.
REQ-017 A start pulse received outside IDLE SHALL be ignored.
REQ-018 Read counters hcount (0..FRAME_WIDTH-1) and liney (0..FRAME_HEIGHT-1) SHALL clear on entry to READ, and bram_addr SHALL equal liney*FRAME_WIDTH+hcount computed at ADDR_W bits with no truncation.
REQ-019 hcount SHALL wrap to 0 and increment liney when it reaches FRAME_WIDTH-1; liney SHALL not wrap within a frame.
REQ-020 A read SHALL be issued in READ only when fifo_count + inflight < FIFO_DEPTH, with FIFO_DEPTH = BRAM_LATENCY+2 and inflight being the pop-count of a BRAM_LATENCY-long issue-valid shift register.
REQ-021 Returning BRAM data SHALL be pushed into the pixel FIFO together with its line-end and frame-end tags, and the FIFO SHALL never overflow.
REQ-022 axiov SHALL be high exactly when the FIFO is non-empty.
REQ-023 With axiord held high, the first pixel SHALL appear BRAM_LATENCY+1 cycles after start, and one pixel SHALL then transfer every cycle with no bubbles.
REQ-024 axiol SHALL be high for pixel indices hcount = FRAME_WIDTH-1, and frame_done SHALL be high only for pixel index FRAME_WIDTH*FRAME_HEIGHT-1.
REQ-025 The pixel order SHALL be raster order from address 0 upward; no pixel SHALL be dropped or duplicated under any axiord pattern.
REQ-026 A start arriving on the same cycle as the final transfer SHALL be ignored; a new start is accepted only when the FSM is in IDLE.

Reset
REQ-027 When rst is low at a clock edge, the block SHALL enter IDLE, flush the FIFO and the in-flight register, and clear hcount and liney.
REQ-028 During and after reset, the outputs SHALL be axiov=0, axiol=0, frame_done=0, busy=0, bram_addr=0 and axiod=0.
REQ-029 Reset SHALL take priority over start and abort any frame in progress; BRAM data returning after reset SHALL be discarded.

Structure
REQ-030 A shared package fb_pkg SHALL hold the pixel typedef (12-bit RGB444), the default FRAME_WIDTH/FRAME_HEIGHT constants and the FSM state enum, for use by both the framebuffer writer and this reader.
REQ-031 The FIFO SHALL be a sub-module pixel_fifo (depth FIFO_DEPTH, width 14 = pixel plus two tags, with count output) that is synchronous and active-low reset.

Verification
REQ-032 The bench SHALL cover: W=4, H=3, latency 2, BRAM holding addr value, axiord=1, start -> pixels 0..11 on consecutive cycles, first at cycle 3, axiol on 3/7/11, frame_done on 11 only.
REQ-033 The bench SHALL cover: same setup with axiord random at 30% -> identical 0..11 sequence, outputs stable while stalled, FIFO count never above 4.
REQ-034 The bench SHALL cover: axiord=0 for 20 cycles after start -> exactly 4 reads issued, axiov=1 with axiod=0 held, and the stream resumes without loss.
REQ-035 The bench SHALL cover: rst low at pixel 5 -> next cycle axiov=0 and busy=0, with no stale data after a new start and the stream restarting at 0.
REQ-036 The bench SHALL cover: start pulsed mid-frame and on the final-transfer cycle -> ignored, with exactly 12 pixels transferred.
REQ-037 The bench SHALL cover: defaults 240x320 -> last bram_addr 76799 (no 16-bit wrap) and 76800 transfers with one frame_done.
